// File: rtl/prng_pkg.sv
// prng_pkg - shared types and helpers for the prng_draw random source.
//   draw_state_e : draw FSM states (IDLE, SHIFT, CHECK).
//   lfsr_next()  : one Fibonacci LFSR step on a zero-extended word.
package prng_pkg;

  // Widest LFSR the step helper supports; callers zero-extend into it.
  localparam int LFSR_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } draw_state_e;

  // Returns {fb, value[width-1:1]} where fb is the XOR of the tapped bits.
  // Bits at and above 'width' in 'value' must be zero.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] value,
    input logic [LFSR_MAX_W-1:0] taps,
    input int                    width
  );
    logic                  fb_s;
    logic [LFSR_MAX_W-1:0] fb_word_s;
    fb_s      = ^(value & taps);
    fb_word_s = {{(LFSR_MAX_W-1){1'b0}}, fb_s} << (width - 32'sd1);
    return (value >> 1'b1) | fb_word_s;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core - WIDTH-bit Fibonacci LFSR with snapshot/replay.
//   clk, reset   : clock, synchronous active-high reset
//   shift_en     : advance the LFSR by one step this cycle
//   randomize    : free-run request; its falling edge captures the snapshot
//   rerun        : restore the LFSR from the snapshot
//   load         : load LFSR and snapshot from load_data (zero -> SEED)
//   load_data    : load value
//   lfsr         : current LFSR value
module lfsr_core
  import prng_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'h002D,
  parameter logic [WIDTH-1:0] SEED  = 16'h0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             randomize,
  input  logic             rerun,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] lfsr
);

  logic [WIDTH-1:0] lfsr_r;
  logic [WIDTH-1:0] snap_r;
  logic [WIDTH-1:0] load_val_s;
  logic [WIDTH-1:0] shifted_s;
  logic             randomize_d_r;
  logic             fall_s;

  // An all-zero LFSR would lock up, so a zero load falls back to SEED.
  assign load_val_s = (load_data == {WIDTH{1'b0}}) ? SEED : load_data;
  assign shifted_s  = WIDTH'(lfsr_next(LFSR_MAX_W'(lfsr_r), LFSR_MAX_W'(TAPS), WIDTH));
  assign fall_s     = ~randomize & randomize_d_r;
  assign lfsr       = lfsr_r;

  // LFSR register: load beats rerun beats shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r <= SEED;
    end else if (load) begin
      lfsr_r <= load_val_s;
    end else if (rerun) begin
      lfsr_r <= snap_r;
    end else if (shift_en) begin
      lfsr_r <= shifted_s;
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  // Snapshot register: captures the unshifted value on randomize falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_r <= SEED;
    end else if (load) begin
      snap_r <= load_val_s;
    end else if (fall_s) begin
      snap_r <= lfsr_r;
    end else begin
      snap_r <= snap_r;
    end
  end

  // Delayed randomize for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      randomize_d_r <= 1'b0;
    end else begin
      randomize_d_r <= randomize;
    end
  end

endmodule

// File: rtl/prng_draw.sv
// prng_draw - LFSR random source with request/valid symbol draws.
//   clk, reset   : clock, synchronous active-high reset
//   randomize    : free-run shift while high; falling edge snapshots
//   rerun        : restore LFSR from snapshot (aborts a draw in progress)
//   load         : load LFSR and snapshot (aborts a draw in progress)
//   load_data    : load value
//   draw_req     : symbol request, accepted while draw_ready is high
//   draw_ready   : high in IDLE
//   sym_valid    : one-cycle pulse when sym is updated
//   sym          : drawn symbol in [0, SYM_RANGE)
//   state_out    : current LFSR value
module prng_draw
  import prng_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] TAPS       = 16'h002D,
  parameter logic [WIDTH-1:0] SEED       = 16'h0001,
  parameter int               SYM_BITS   = 2,
  parameter int               SYM_RANGE  = 4,
  parameter int               MAX_REJECT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                randomize,
  input  logic                rerun,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_data,
  input  logic                draw_req,
  output logic                draw_ready,
  output logic                sym_valid,
  output logic [SYM_BITS-1:0] sym,
  output logic [WIDTH-1:0]    state_out
);

  localparam int BC_W = $clog2(SYM_BITS + 1);
  localparam int RC_W = $clog2(MAX_REJECT + 1);
  localparam logic [BC_W-1:0]     BIT_LAST = BC_W'(SYM_BITS - 1);
  localparam logic [RC_W-1:0]     REJ_LAST = RC_W'(MAX_REJECT - 1);
  localparam logic [SYM_BITS:0]   RANGE_W  = (SYM_BITS + 1)'(SYM_RANGE);
  localparam logic [SYM_BITS-1:0] RANGE_LO = RANGE_W[SYM_BITS-1:0];

  draw_state_e         state_r, state_nxt_s;
  logic [BC_W-1:0]     bit_cnt_r;
  logic [RC_W-1:0]     rej_cnt_r;
  logic [SYM_BITS-1:0] cand_r;
  logic [SYM_BITS-1:0] cand_shift_s;
  logic [SYM_BITS-1:0] sym_r;
  logic                sym_valid_r;
  logic [WIDTH-1:0]    lfsr_s;
  logic                shift_en_s;
  logic                abort_s;
  logic                cand_ok_s;
  logic                rej_more_s;
  logic                draw_ready_s;
  logic                emit_ok_s;
  logic                emit_forced_s;
  logic                reject_s;

  assign abort_s      = load | rerun;
  assign cand_ok_s    = ({1'b0, cand_r} < RANGE_W);
  assign rej_more_s   = (rej_cnt_r < REJ_LAST);
  // New LFSR bit enters at the candidate MSB; older bits move down.
  assign cand_shift_s = SYM_BITS'({lfsr_s[0], cand_r} >> 1'b1);
  // randomize shifts alongside SHIFT but the core steps at most once per cycle.
  assign shift_en_s   = randomize | (state_r == SHIFT);

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (shift_en_s),
    .randomize (randomize),
    .rerun     (rerun),
    .load      (load),
    .load_data (load_data),
    .lfsr      (lfsr_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (draw_req) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (abort_s) begin
          state_nxt_s = IDLE;
        end else if (bit_cnt_r == BIT_LAST) begin
          state_nxt_s = CHECK;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      CHECK: begin
        if (abort_s || cand_ok_s || !rej_more_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: ready flag and CHECK-stage decisions.
  always_comb begin
    draw_ready_s  = 1'b0;
    emit_ok_s     = 1'b0;
    emit_forced_s = 1'b0;
    reject_s      = 1'b0;
    case (state_r)
      IDLE:  draw_ready_s = 1'b1;
      SHIFT: draw_ready_s = 1'b0;
      CHECK: begin
        if (abort_s) begin
          reject_s = 1'b0;
        end else if (cand_ok_s) begin
          emit_ok_s = 1'b1;
        end else if (rej_more_s) begin
          reject_s = 1'b1;
        end else begin
          emit_forced_s = 1'b1;
        end
      end
      default: draw_ready_s = 1'b0;
    endcase
  end

  // Draw datapath: bit/reject counters and candidate assembly.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_r <= {BC_W{1'b0}};
      rej_cnt_r <= {RC_W{1'b0}};
      cand_r    <= {SYM_BITS{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          bit_cnt_r <= {BC_W{1'b0}};
          rej_cnt_r <= {RC_W{1'b0}};
        end
        SHIFT: begin
          cand_r    <= cand_shift_s;
          bit_cnt_r <= bit_cnt_r + BC_W'(1'b1);
        end
        CHECK: begin
          if (reject_s) begin
            rej_cnt_r <= rej_cnt_r + RC_W'(1'b1);
            bit_cnt_r <= {BC_W{1'b0}};
          end else begin
            rej_cnt_r <= rej_cnt_r;
          end
        end
        default: bit_cnt_r <= {BC_W{1'b0}};
      endcase
    end
  end

  // Registered symbol outputs; a capped draw folds the candidate into range.
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_r       <= {SYM_BITS{1'b0}};
      sym_valid_r <= 1'b0;
    end else begin
      sym_valid_r <= emit_ok_s | emit_forced_s;
      if (emit_ok_s) begin
        sym_r <= cand_r;
      end else if (emit_forced_s) begin
        sym_r <= cand_r - RANGE_LO;
      end else begin
        sym_r <= sym_r;
      end
    end
  end

  assign draw_ready = draw_ready_s;
  assign sym_valid  = sym_valid_r;
  assign sym        = sym_r;
  assign state_out  = lfsr_s;

endmodule

// File: doc/prng_draw.md
# prng_draw

Parametrised Fibonacci LFSR random source with snapshot/replay and a request/valid symbol-draw port. It replaces the fixed 16-bit, tap-hardwired generator. Game logic requests uniformly distributed symbols in [0, SYM_RANGE), for example a colour index. The current sequence can be frozen at the end of a randomize period and replayed on demand.

## Interface
- WIDTH, 16: LFSR width (≥ 4).
- TAPS, 16'h002D: feedback mask; fb = XOR of lfsr bits where TAPS bit = 1.
- SEED, 1: reset value; also replaces any zero load; must be non-zero.
- SYM_BITS, 2: bits per drawn symbol.
- SYM_RANGE, 4: symbol range; 2^(SYM_BITS-1) < SYM_RANGE ≤ 2^SYM_BITS.
- MAX_REJECT, 4: rejection cap per draw (≥ 1).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- randomize  in  1  free-run shift while high; its falling edge captures the snapshot.
- rerun  in  1  restore the LFSR from the snapshot.
- load  in  1  load the LFSR and snapshot from load_data.
- load_data  in  WIDTH  load value.
- draw_req  in  1  symbol request.
- draw_ready  out  1  high in IDLE (combinational from state).
- sym_valid  out  1  one-cycle pulse, registered.
- sym  out  SYM_BITS  drawn symbol, registered, held until next pulse.
- state_out  out  WIDTH  current LFSR value.

## Operation
- Shift: lfsr <= {fb, lfsr[WIDTH-1:1]}. At most one shift per cycle.
- Shift enable = randomize | (FSM in SHIFT).
- Register-update priority: reset > load > rerun > shift.
- load: lfsr and snapshot both take load_data. A zero load_data is replaced by SEED.
- rerun: lfsr <= snapshot.
- randomize_d is reset to 0.
- Falling edge (~randomize & randomize_d): snapshot <= lfsr, the unshifted current value. If load occurs in the same cycle, load wins.
- FSM states:
  - IDLE: draw_req accepted → SHIFT, bit count = 0, reject count = 0.
  - SHIFT: each cycle cand <= {lfsr[0], cand[SYM_BITS-1:1]} and the LFSR shifts. After SYM_BITS cycles → CHECK.
  - CHECK:
    - If cand < SYM_RANGE: sym <= cand, sym_valid <= 1, → IDLE.
    - Else if reject count + 1 < MAX_REJECT: reject count++, → SHIFT.
    - Else: sym <= cand − SYM_RANGE, sym_valid <= 1, → IDLE.
- rerun or load in SHIFT/CHECK aborts the draw: → IDLE, no sym_valid.
- Reset values: lfsr = SEED, snapshot = SEED, state IDLE, sym = 0, sym_valid = 0, draw_ready = 1, state_out = SEED.

## Timing
- Accept occurs on the edge where draw_req & draw_ready are both high.
- With no rejection, sym_valid is high in the cycle after SYM_BITS+1 further edges: latency SYM_BITS+2 edges from accept.
- Each rejection adds SYM_BITS+1 cycles.
- sym_valid coincides with IDLE, so a back-to-back draw_req is accepted in the same cycle.
- randomize during a draw adds no extra shifts.
- A rerun and the falling edge of randomize in the same cycle: the snapshot captures the pre-restore lfsr, and lfsr takes the old snapshot.

## Structure
- Package prng_pkg holds:
  - the FSM state enum (IDLE, SHIFT, CHECK);
  - the function lfsr_next(value, taps), which returns the shifted word.
- Sub-module lfsr_core: the WIDTH-bit register with shift enable, load, restore, the snapshot register, and randomize edge detection.
- prng_draw contains the FSM, candidate assembly and the output registers.

## Test plan
- Reset, defaults, one draw → sym = 1 at edge 4 after accept; state_out = 0x4000. A second draw → sym = 0, state_out = 0x1000.
- Reset, randomize high for 3 cycles then low → state_out = 0x2000 and snapshot = 0x2000. Two further draws, then rerun → state_out = 0x2000 next cycle.
- SYM_RANGE = 3, load_data = 0x0003, draw → first cand = 3 is rejected, second cand = 0 is accepted. sym = 0 at edge 7 after accept; state_out = 0x3000.
- SYM_RANGE = 3, MAX_REJECT = 1, load_data = 0x0003, draw → forced output sym = 0 after 4 edges.
- load_data = 0 → state_out = SEED (0x0001); a draw then behaves as after reset.
- Draw accepted, rerun on the 2nd SHIFT cycle → no sym_valid; draw_ready = 1 next cycle; state_out = snapshot.
